uart_txb_arbiter: RTL and testbench
===================================

# uart_txb_arbiter

Round-robin arbiter that shares the single UART transmit-buffer stream port (o_txb_tvalid / i_txb_tready / o_txb_tdata) among NUM_REQ byte-stream requesters, for example the AXI write controller, a DMA engine and a debug console. Arbitration is packet-granular: a grant is held until the requester's tlast beat, or until MAX_BURST beats have been accepted, whichever comes first. The block sits between the requesters and the TX FIFO, upstream of the UART transmitter.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- UART_DLEN, default 8: data width per beat.
- MAX_BURST, default 16: beat limit per grant before forced re-arbitration, 1..255.

Ports:
- clk  in  1  single clock domain
- rstn  in  1  reset; asynchronous, active-low
- i_req_en  in  NUM_REQ  per-requester enable mask; sampled only during arbitration
- i_req_tvalid  in  NUM_REQ  requester stream valid
- o_req_tready  out  NUM_REQ  requester stream ready
- i_req_tdata  in  NUM_REQ*UART_DLEN  requester data; requester k occupies bits [k*UART_DLEN +: UART_DLEN]
- i_req_tlast  in  NUM_REQ  last beat of the requester's packet
- o_txb_tvalid  out  1  to TX buffer
- i_txb_tready  in  1  from TX buffer
- o_txb_tdata  out  UART_DLEN  to TX buffer
- o_grant  out  NUM_REQ  one-hot current grant; all zeros when idle
- o_busy  out  1  high while in XFER
- o_forced  out  1  one-cycle pulse when a grant ends on MAX_BURST rather than tlast

## Operation
- States: IDLE and XFER.
- IDLE
  - Candidates = i_req_tvalid & i_req_en.
  - If any candidate exists, select the first one in circular order starting at rr_ptr+1 (mod NUM_REQ).
  - Register the selection into the grant, clear beat_cnt to 0, and move to XFER.
  - If no candidate exists, remain in IDLE.
- XFER, granted index g
  - o_txb_tvalid = i_req_tvalid[g], o_txb_tdata = requester g's data, o_req_tready[g] = i_txb_tready.
  - All other o_req_tready are 0.
  - A beat is accepted when o_txb_tvalid & i_txb_tready; each accepted beat increments beat_cnt.
  - Exit to IDLE when an accepted beat has i_req_tlast[g] = 1, or when the accepted beat brings beat_cnt to MAX_BURST.
  - On exit, rr_ptr <= g and the grant clears.
- o_forced = 1 in the exit cycle only when the exit was caused by the limit and tlast was 0. If tlast and the limit coincide, o_forced = 0.
- i_req_en changes in XFER do not revoke the current grant. The mask applies only at the next arbitration.
- A granted requester that drops tvalid stalls the port (o_txb_tvalid = 0). The grant is held; there is no timeout.
- When idle: o_txb_tvalid = 0, o_txb_tdata = 0, all o_req_tready = 0.
- beat_cnt width is $clog2(MAX_BURST+1). It never wraps, because the exit occurs at MAX_BURST.

## Timing
- Reset (async assert, sync deassert handled externally) forces state = IDLE, grant = 0, rr_ptr = NUM_REQ-1 so requester 0 has first priority, and beat_cnt = 0.
- Output values during reset: o_txb_tvalid = 0, o_txb_tdata = 0, o_req_tready = 0, o_grant = 0, o_busy = 0, o_forced = 0.
- Arbitration latency is 1 cycle: a candidate visible at edge N is granted from cycle N+1. Its first beat can be accepted in cycle N+1.
- Data, valid and ready are combinational paths through the granted mux. There is no added register stage.
- Between consecutive grants there is exactly one idle bubble cycle: the exit beat is at cycle M, IDLE is at cycle M+1, and the next grant starts at cycle M+2.
- Asserting rstn low in mid-packet drops the grant immediately. The partial packet is not resumed.

## Structure
- Shared package uart_pkg holds the arb_state_e enum (ARB_IDLE, ARB_XFER).
- Sub-module rr_select is a combinational circular priority picker.
  - Inputs: req[NUM_REQ] and ptr.
  - Outputs: a one-hot gnt and a valid flag.
  - It is reusable by the future RX distribution block.
- The top level holds the FSM, beat_cnt, rr_ptr and the output muxes.

## Test plan
- Single requester: requester 0 sends 3 beats 0x41, 0x42, 0x43 with tlast on 0x43, i_txb_tready = 1 → o_grant = 0001 from the cycle after tvalid, TX receives 41/42/43 on consecutive cycles, o_forced stays 0, IDLE follows.
- Fairness: all 4 requesters continuously valid with 1-beat packets → grant order 0, 1, 2, 3, 0, with one bubble between grants.
- Burst limit: MAX_BURST = 4, requester 2 sends 6 beats with tlast only on beat 6 → grant ends after beat 4 with o_forced = 1. The next grant goes to requester 3 if it is valid, otherwise back to requester 2 for the remaining 2 beats.
- Backpressure: i_txb_tready low for 5 cycles mid-packet → o_req_tready[g] low for the same 5 cycles, no beat lost or duplicated, beat_cnt unchanged.
- Mask: clear i_req_en[1] while requester 1 is granted → its packet completes. At the next arbitration, requester 1 is skipped even though it is valid.
- Reset mid-packet: drop rstn asynchronously between clock edges during beat 2 → all outputs are 0 immediately. After release, requester 0 wins first priority.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART-side types: arbiter FSM state encoding.
package uart_pkg;

   typedef enum logic [0:0] {
      ARB_IDLE = 1'b0,
      ARB_XFER = 1'b1
   } arb_state_e;

endpackage

// File: rtl/uart_txb_arbiter_if.sv
// Requester-side and TX-buffer-side stream signals of the TX-buffer arbiter.
interface uart_txb_arbiter_if #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned UART_DLEN = 8
);
   logic [NUM_REQ-1:0]           i_req_en;
   logic [NUM_REQ-1:0]           i_req_tvalid;
   logic [NUM_REQ-1:0]           o_req_tready;
   logic [NUM_REQ*UART_DLEN-1:0] i_req_tdata;
   logic [NUM_REQ-1:0]           i_req_tlast;
   logic                         o_txb_tvalid;
   logic                         i_txb_tready;
   logic [UART_DLEN-1:0]         o_txb_tdata;
   logic [NUM_REQ-1:0]           o_grant;
   logic                         o_busy;
   logic                         o_forced;

   // Environment side: requesters plus the TX buffer
   modport master (
      output i_req_en, i_req_tvalid, i_req_tdata, i_req_tlast, i_txb_tready,
      input  o_req_tready, o_txb_tvalid, o_txb_tdata, o_grant, o_busy, o_forced
   );

   // Arbiter side
   modport slave (
      input  i_req_en, i_req_tvalid, i_req_tdata, i_req_tlast, i_txb_tready,
      output o_req_tready, o_txb_tvalid, o_txb_tdata, o_grant, o_busy, o_forced
   );
endinterface

// File: rtl/uart_txb_arbiter_rr_select.sv
// Combinational circular priority picker: first set request after ptr, wrapping.
module rr_select #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt,
   output logic               valid
);

   int unsigned       pos;
   logic [PTR_W-1:0]  idx;

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         pos = 32'(ptr) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = PTR_W'(pos);
         if (!valid && req[idx]) begin
            gnt[idx] = 1'b1;
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_txb_arbiter.sv
// Packet-granular round-robin arbiter sharing the UART TX-buffer stream port.
module uart_txb_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned UART_DLEN = 8,
   parameter int unsigned MAX_BURST = 16
) (
   input logic               clk,
   input logic               rstn,
   uart_txb_arbiter_if.slave bus
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   arb_state_e           state_q, state_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d, gnt_idx;
   logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
   logic                 forced_q, forced_d, busy_q;
   logic [NUM_REQ-1:0]   cand, sel_gnt;
   logic                 sel_valid;
   logic [UART_DLEN-1:0] txb_tdata;
   logic                 txb_tvalid, tlast_g, beat_acc, limit_hit;

   assign cand = bus.i_req_tvalid & bus.i_req_en;

   rr_select #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr_select (
      .req   (cand),
      .ptr   (ptr_q),
      .gnt   (sel_gnt),
      .valid (sel_valid)
   );

   // Granted-requester mux; a zero grant yields all-zero outputs
   always_comb begin
      txb_tdata = '0;
      gnt_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (grant_q[k]) begin
            txb_tdata = txb_tdata | bus.i_req_tdata[k*UART_DLEN +: UART_DLEN];
            gnt_idx   = PTR_W'(k);
         end
      end
   end

   assign txb_tvalid = |(grant_q & bus.i_req_tvalid);
   assign tlast_g    = |(grant_q & bus.i_req_tlast);
   assign beat_acc   = txb_tvalid & bus.i_txb_tready;
   assign cnt_inc    = cnt_q + CNT_W'(1);
   assign limit_hit  = (cnt_inc == CNT_W'(MAX_BURST));

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      cnt_d    = cnt_q;
      forced_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (sel_valid) begin
               grant_d = sel_gnt;
               cnt_d   = '0;
               state_d = ARB_XFER;
            end
         end
         ARB_XFER: begin
            if (beat_acc) begin
               cnt_d = cnt_inc;
               if (tlast_g || limit_hit) begin
                  state_d  = ARB_IDLE;
                  grant_d  = '0;
                  ptr_d    = gnt_idx;
                  cnt_d    = '0;
                  forced_d = limit_hit & ~tlast_g;
               end
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Reset leaves requester 0 first in line
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ARB_IDLE;
         grant_q  <= '0;
         ptr_q    <= PTR_W'(NUM_REQ - 1);
         cnt_q    <= '0;
         forced_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         forced_q <= forced_d;
         busy_q   <= (state_d == ARB_XFER);
      end
   end

   assign bus.o_txb_tvalid = txb_tvalid;
   assign bus.o_txb_tdata  = txb_tdata;
   assign bus.o_req_tready = grant_q & {NUM_REQ{bus.i_txb_tready}};
   assign bus.o_grant      = grant_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_forced     = forced_q;

endmodule

// File: tb/tb_uart_txb_arbiter.sv
// Directed bench for uart_txb_arbiter (4 requesters, MAX_BURST = 4).
module tb_uart_txb_arbiter;

   logic clk;
   logic rstn;
   int   checks;
   int   failures;

   uart_txb_arbiter_if #(.NUM_REQ(4), .UART_DLEN(8)) bus ();

   uart_txb_arbiter #(.NUM_REQ(4), .UART_DLEN(8), .MAX_BURST(4)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic v, input logic [7:0] d, input logic l);
      bus.i_req_tvalid[k]      = v;
      bus.i_req_tdata[k*8 +: 8] = d;
      bus.i_req_tlast[k]       = l;
   endtask

   task automatic clear_inputs();
      bus.i_req_en     = 4'b1111;
      bus.i_req_tvalid = '0;
      bus.i_req_tdata  = '0;
      bus.i_req_tlast  = '0;
      bus.i_txb_tready = 1'b1;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      logic [18:0] outs;
      clear_inputs();
      rstn = 1'b0;
      #2;
      outs = {bus.o_txb_tvalid, bus.o_txb_tdata, bus.o_req_tready, bus.o_grant, bus.o_busy, bus.o_forced};
      checks++;
      if (outs !== 19'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%h exp=0", outs);
      end
      do_reset();
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset_release grant=%b busy=%b exp grant=0000 busy=0", bus.o_grant, bus.o_busy);
      end
   endtask

   task automatic test_single();
      logic [7:0] exp_d [3] = '{8'h41, 8'h42, 8'h43};
      set_req(0, 1'b1, 8'h41, 1'b0);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_txb_tvalid !== 1'b0) begin
         failures++;
         $display("FAIL single_pre_grant grant=%b tvalid=%b exp 0000/0", bus.o_grant, bus.o_txb_tvalid);
      end
      tick();
      for (int b = 0; b < 3; b++) begin
         set_req(0, 1'b1, exp_d[b], (b == 2));
         #1;
         checks++;
         if (bus.o_grant !== 4'b0001 || bus.o_txb_tvalid !== 1'b1 || bus.o_txb_tdata !== exp_d[b] ||
             bus.o_req_tready !== 4'b0001 || bus.o_busy !== 1'b1 || bus.o_forced !== 1'b0) begin
            failures++;
            $display("FAIL single_beat%0d grant=%b tvalid=%b data=%h rdy=%b busy=%b forced=%b exp 0001/1/%h/0001/1/0",
                     b, bus.o_grant, bus.o_txb_tvalid, bus.o_txb_tdata, bus.o_req_tready,
                     bus.o_busy, bus.o_forced, exp_d[b]);
         end
         tick();
      end
      set_req(0, 1'b0, 8'h00, 1'b0);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0 || bus.o_forced !== 1'b0 ||
          bus.o_txb_tdata !== 8'h00) begin
         failures++;
         $display("FAIL single_idle grant=%b busy=%b forced=%b data=%h exp 0000/0/0/00",
                  bus.o_grant, bus.o_busy, bus.o_forced, bus.o_txb_tdata);
      end
   endtask

   task automatic test_fairness();
      int         ord [5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_g;
      logic [7:0] exp_d;
      do_reset();
      for (int k = 0; k < 4; k++) set_req(k, 1'b1, 8'hA0 + 8'(k), 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         exp_g = 4'b0001 << ord[i];
         exp_d = 8'hA0 + 8'(ord[i]);
         checks++;
         if (bus.o_grant !== exp_g || bus.o_txb_tdata !== exp_d) begin
            failures++;
            $display("FAIL fair_grant%0d grant=%b data=%h exp %b/%h", i, bus.o_grant, bus.o_txb_tdata, exp_g, exp_d);
         end
         tick();
         checks++;
         if (bus.o_grant !== 4'b0000 || bus.o_txb_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL fair_bubble%0d grant=%b tvalid=%b exp 0000/0", i, bus.o_grant, bus.o_txb_tvalid);
         end
      end
      clear_inputs();
   endtask

   task automatic test_burst_limit();
      int b = 0;
      set_req(2, 1'b1, 8'h21, 1'b0);
      tick();
      for (int j = 0; j < 4; j++) begin
         #1;
         checks++;
         if (bus.o_grant !== 4'b0100 || bus.o_txb_tdata !== 8'h21 + 8'(b) || bus.o_forced !== 1'b0) begin
            failures++;
            $display("FAIL burst_beat%0d grant=%b data=%h forced=%b exp 0100/%h/0",
                     j, bus.o_grant, bus.o_txb_tdata, bus.o_forced, 8'h21 + 8'(b));
         end
         tick();
         b++;
         set_req(2, 1'b1, 8'h21 + 8'(b), (b == 5));
      end
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_forced !== 1'b1 || bus.o_busy !== 1'b0) begin
         failures++;
         $display("FAIL burst_forced grant=%b forced=%b busy=%b exp 0000/1/0", bus.o_grant, bus.o_forced, bus.o_busy);
      end
      tick();
      checks++;
      if (bus.o_grant !== 4'b0100 || bus.o_txb_tdata !== 8'h25 || bus.o_forced !== 1'b0) begin
         failures++;
         $display("FAIL burst_regrant grant=%b data=%h forced=%b exp 0100/25/0", bus.o_grant, bus.o_txb_tdata, bus.o_forced);
      end
      tick();
      b++;
      set_req(2, 1'b1, 8'h21 + 8'(b), 1'b1);
      #1;
      checks++;
      if (bus.o_txb_tdata !== 8'h26 || bus.o_grant !== 4'b0100) begin
         failures++;
         $display("FAIL burst_tail data=%h grant=%b exp 26/0100", bus.o_txb_tdata, bus.o_grant);
      end
      tick();
      set_req(2, 1'b0, 8'h00, 1'b0);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_forced !== 1'b0) begin
         failures++;
         $display("FAIL burst_tlast_exit grant=%b forced=%b exp 0000/0", bus.o_grant, bus.o_forced);
      end
   endtask

   task automatic test_backpressure();
      set_req(0, 1'b1, 8'h51, 1'b0);
      tick();
      checks++;
      if (bus.o_grant !== 4'b0001 || bus.o_txb_tdata !== 8'h51 || bus.o_req_tready !== 4'b0001) begin
         failures++;
         $display("FAIL bp_first grant=%b data=%h rdy=%b exp 0001/51/0001", bus.o_grant, bus.o_txb_tdata, bus.o_req_tready);
      end
      tick();
      set_req(0, 1'b1, 8'h52, 1'b0);
      bus.i_txb_tready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         #1;
         checks++;
         if (bus.o_req_tready !== 4'b0000 || bus.o_grant !== 4'b0001 ||
             bus.o_txb_tvalid !== 1'b1 || bus.o_txb_tdata !== 8'h52) begin
            failures++;
            $display("FAIL bp_stall%0d rdy=%b grant=%b tvalid=%b data=%h exp 0000/0001/1/52",
                     s, bus.o_req_tready, bus.o_grant, bus.o_txb_tvalid, bus.o_txb_tdata);
         end
         tick();
      end
      bus.i_txb_tready = 1'b1;
      #1;
      checks++;
      if (bus.o_req_tready !== 4'b0001 || bus.o_txb_tdata !== 8'h52 || bus.o_forced !== 1'b0) begin
         failures++;
         $display("FAIL bp_resume rdy=%b data=%h forced=%b exp 0001/52/0", bus.o_req_tready, bus.o_txb_tdata, bus.o_forced);
      end
      tick();
      set_req(0, 1'b1, 8'h53, 1'b1);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0001 || bus.o_txb_tdata !== 8'h53) begin
         failures++;
         $display("FAIL bp_last grant=%b data=%h exp 0001/53", bus.o_grant, bus.o_txb_tdata);
      end
      tick();
      set_req(0, 1'b0, 8'h00, 1'b0);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0000 || bus.o_forced !== 1'b0) begin
         failures++;
         $display("FAIL bp_exit grant=%b forced=%b exp 0000/0", bus.o_grant, bus.o_forced);
      end
   endtask

   task automatic test_mask();
      set_req(1, 1'b1, 8'h61, 1'b0);
      tick();
      bus.i_req_en = 4'b1101;
      #1;
      checks++;
      if (bus.o_grant !== 4'b0010 || bus.o_txb_tdata !== 8'h61) begin
         failures++;
         $display("FAIL mask_held grant=%b data=%h exp 0010/61", bus.o_grant, bus.o_txb_tdata);
      end
      tick();
      set_req(1, 1'b1, 8'h62, 1'b1);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0010 || bus.o_txb_tdata !== 8'h62) begin
         failures++;
         $display("FAIL mask_complete grant=%b data=%h exp 0010/62", bus.o_grant, bus.o_txb_tdata);
      end
      tick();
      set_req(1, 1'b1, 8'h63, 1'b1);
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if (bus.o_grant !== 4'b0000 || bus.o_busy !== 1'b0) begin
            failures++;
            $display("FAIL mask_skip%0d grant=%b busy=%b exp 0000/0", s, bus.o_grant, bus.o_busy);
         end
         tick();
      end
      bus.i_req_en = 4'b1111;
      tick();
      checks++;
      if (bus.o_grant !== 4'b0010 || bus.o_txb_tdata !== 8'h63) begin
         failures++;
         $display("FAIL mask_reenable grant=%b data=%h exp 0010/63", bus.o_grant, bus.o_txb_tdata);
      end
      tick();
      set_req(1, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_reset_mid();
      logic [18:0] outs;
      set_req(2, 1'b1, 8'h71, 1'b0);
      tick();
      tick();
      set_req(2, 1'b1, 8'h72, 1'b0);
      #1;
      checks++;
      if (bus.o_grant !== 4'b0100 || bus.o_txb_tdata !== 8'h72) begin
         failures++;
         $display("FAIL rstmid_beat2 grant=%b data=%h exp 0100/72", bus.o_grant, bus.o_txb_tdata);
      end
      #1;
      rstn = 1'b0;
      #1;
      outs = {bus.o_txb_tvalid, bus.o_txb_tdata, bus.o_req_tready, bus.o_grant, bus.o_busy, bus.o_forced};
      checks++;
      if (outs !== 19'd0) begin
         failures++;
         $display("FAIL rstmid_outputs got=%h exp=0", outs);
      end
      set_req(0, 1'b1, 8'h81, 1'b1);
      set_req(3, 1'b1, 8'h83, 1'b1);
      #3;
      rstn = 1'b1;
      tick();
      checks++;
      if (bus.o_grant !== 4'b0001 || bus.o_txb_tdata !== 8'h81) begin
         failures++;
         $display("FAIL rstmid_priority grant=%b data=%h exp 0001/81", bus.o_grant, bus.o_txb_tdata);
      end
      clear_inputs();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rstn     = 1'b0;
      test_reset();
      test_single();
      test_fairness();
      test_burst_limit();
      test_backpressure();
      test_mask();
      test_reset_mid();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
